// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  localparam logic        REDIR_BRANCH = 1'b0;
  localparam logic        REDIR_JALR   = 1'b1;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target generation and alignment check.
// FETCH_MISALIGN_TRAP_EN: when undefined, target bits [1:0] are forced to zero here.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic        redir_sel,
  input  logic [31:0] redir_pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_target,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] raw;

  always_comb begin
    raw = (redir_sel == REDIR_JALR) ? (alu_target & ~32'd1) : (redir_pc + imm_ext);
    misaligned = |raw[1:0];
`ifdef FETCH_MISALIGN_TRAP_EN
    target = raw;
`else
    target = {raw[31:2], 2'b00};
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// RISC-V fetch stage: PC, one-outstanding imem interface, valid/ready to decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets set misalign_fault and halt fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        redir_valid,
  input  logic        redir_sel,
  input  logic [31:0] redir_pc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] alu_target,
  output logic        misalign_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_tgt;
  logic         tgt_misaligned;
  logic         redir_act;

  next_pc_calc u_next_pc (
    .redir_sel  (redir_sel),
    .redir_pc   (redir_pc),
    .imm_ext    (ImmExt),
    .alu_target (alu_target),
    .target     (redir_tgt),
    .misaligned (tgt_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    redir_act  = redir_valid && (state_q inside {FETCH, HOLD, DRAIN});
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (redir_valid) begin
          // A response in the redirect cycle is dropped; otherwise it is still in flight.
          state_d = imem_rvalid ? FETCH : DRAIN;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redir_valid)      state_d = FETCH;
        else if (instr_ready) begin
          fetch_pc_d = pc_q + 32'd4;
          state_d    = FETCH;
        end
      end
      DRAIN: if (imem_rvalid) state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT:  state_d = HALT;
`endif
      default: state_d = BOOT;
    endcase
    // fetch_pc doubles as the latched target while draining; no request is up then.
    if (redir_act) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt_misaligned) state_d = HALT;
      else
`endif
      fetch_pc_d = redir_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign fault_d = fault_q | (state_d == HALT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign misalign_fault = fault_q;
`else
  logic unused_misalign;
  assign unused_misalign = tgt_misaligned;
  assign misalign_fault  = 1'b0;
`endif

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a latency-randomized memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_rvalid, instr_valid, instr_ready, redir_valid, redir_sel;
  logic        misalign_fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, redir_pc, imm_ext, alu_target;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc(redir_pc),
    .ImmExt(imm_ext), .alu_target(alu_target), .misalign_fault(misalign_fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0001_3579;
  endfunction

  // ---------------- memory model ----------------
  bit          boot_rsp = 1'b0;
  int          lat_fix = 1;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = '0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy        = 1'b0;
        imem_rvalid = boot_rsp;
        imem_rdata  = 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(maddr);
            busy        = 1'b0;
          end
        end else if (imem_req) begin
          busy  = 1'b1;
          maddr = imem_addr;
          cnt   = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [31:0] expq[$];
  logic [31:0] cur_exp = '0;
  bit          presented = 1'b0;
  bit          halted = 1'b0;
  int          idle = 0;
  int          delivered = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        expq.push_back(32'h0);
        presented = 1'b0;
        halted    = 1'b0;
        idle      = 0;
      end else if (halted) begin
        chk1("halt_fault", misalign_fault, 1'b1);
        chk1("halt_req", imem_req, 1'b0);
        chk1("halt_valid", instr_valid, 1'b0);
      end else begin
        if (imem_req) begin
          if (expq.size() == 0) chk1("req_unexpected", imem_req, 1'b0);
          else chk("imem_addr", imem_addr, expq[0]);
        end
        if (instr_valid) begin
          idle = 0;
          if (!presented) begin
            if (expq.size() == 0) chk1("valid_unexpected", instr_valid, 1'b0);
            else cur_exp = expq.pop_front();
            presented = 1'b1;
            delivered++;
          end
          chk("pc", pc, cur_exp);
          chk("instr", instr, memf(cur_exp));
          chk("pc_plus4", pc_plus4, cur_exp + 32'd4);
          chk1("req_in_hold", imem_req, 1'b0);
          chk1("fault_clear", misalign_fault, 1'b0);
        end else begin
          idle++;
          if (idle > 100) begin
            chk1("watchdog_valid", instr_valid, 1'b1);
            idle = 0;
          end
        end
        if (redir_valid) begin
          logic [31:0] t;
          t = redir_sel ? (alu_target & ~32'd1) : (redir_pc + imm_ext);
          expq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
          if (t[1:0] != 2'b00) halted = 1'b1;
          else expq.push_back(t);
`else
          expq.push_back({t[31:2], 2'b00});
`endif
          presented = 1'b0;
        end else if (instr_valid && instr_ready) begin
          expq.push_back(cur_exp + 32'd4);
          presented = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input bit inject);
    @(posedge clk); #3;
    rst = 1'b1; boot_rsp = inject; redir_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_fault", misalign_fault, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0; boot_rsp = 1'b0;
    @(negedge clk); chk1("boot_no_req", imem_req, 1'b0);
    @(negedge clk); chk1("first_req", imem_req, 1'b1);
  endtask

  task automatic run(input int n, input bit rnd, input bit rdy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      redir_valid = 1'b0;
      instr_ready = rnd ? ($urandom_range(0, 2) != 0) : rdy;
      if (rnd && $urandom_range(0, 9) == 0) begin
        redir_valid = 1'b1;
        redir_sel   = 1'($urandom_range(0, 1));
        redir_pc    = $urandom;
        imm_ext     = $urandom;
        alu_target  = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        redir_pc   = redir_pc & ~32'd3;
        imm_ext    = imm_ext & ~32'd3;
        alu_target = alu_target & ~32'd2;
`endif
      end
    end
  endtask

  task automatic issue(input logic sel, input logic [31:0] rpc, input logic [31:0] imm,
                       input logic [31:0] alu);
    @(posedge clk); #2;
    redir_valid = 1'b1; instr_ready = 1'b1;
    redir_sel = sel; redir_pc = rpc; imm_ext = imm; alu_target = alu;
    @(posedge clk); #2;
    redir_valid = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic wait_valid();
    @(posedge clk); #2;
    redir_valid = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    chk1("wait_valid", instr_valid, 1'b1);
  endtask

  initial begin
    instr_ready = 1'b0; redir_valid = 1'b0; redir_sel = 1'b0;
    redir_pc = '0; imm_ext = '0; alu_target = '0;
    lat_fix = 1;
    do_reset(1'b1);
    run(12, 1'b0, 1'b1);
    wait_valid();
    run(5, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1);
    wait_valid();
    issue(1'b0, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0);
    run(10, 1'b0, 1'b1);
    lat_fix = 4;
    wait_valid();
    run(1, 1'b0, 1'b1);
    issue(1'b1, 32'h0, 32'h0, 32'h0000_0201);
    run(15, 1'b0, 1'b1);
    lat_fix = 1;
    wait_valid();
    issue(1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0);
    run(10, 1'b0, 1'b1);
    lat_fix = 0;
    run(1500, 1'b1, 1'b1);
    lat_fix = 1;
    wait_valid();
    issue(1'b0, 32'h0000_0100, 32'h0000_0002, 32'h0);
    run(8, 1'b0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset(1'b0);
    run(10, 1'b0, 1'b1);
`endif
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL delivered got %0d want >=50", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
